uart_tx_fifo_drain: RTL
=======================

// Module: uart_tx_fifo_drain
// PURPOSE
//   Reader end of the 16x8 byte FIFO: pops bytes from the FIFO read port and serializes
//   them as 8N1/8E1/8O1 UART frames on tx. Sits between the sensor/watch formatting logic,
//   which writes the FIFO, and the board TX pin. Drains continuously while tx_en=1 and the
//   FIFO is non-empty.
// PARAMETERS
//   CLK_HZ     100_000_000  system clock frequency, Hz
//   BAUD       9600         line rate; DIV = CLK_HZ/BAUD (integer divide), DIV >= 2 required
//   PARITY     0            0 = none, 1 = even, 2 = odd
//   STOP_BITS  1            1 or 2 stop bits
// PORTS
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset (0 = in reset)
//   tx_en       in   1  1 = allowed to start a new frame; sampled only in IDLE
//   fifo_empty  in   1  FIFO empty flag
//   fifo_rdata  in   8  FIFO head byte; combinational show-ahead, valid whenever fifo_empty=0
//   fifo_rd     out  1  pop strobe, one cycle per byte
//   tx          out  1  serial line, idles high
//   tx_busy     out  1  1 from the LOAD cycle through the last stop-bit cycle
//   tx_done     out  1  one-cycle pulse on the final cycle of the last stop bit
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_rd=0, baud
//     counter=0, bit index=0, shift reg=0. A frame in progress is abandoned: the line goes
//     high immediately and the already-popped byte is lost; it is not re-read.
//   FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
//   IDLE:   tx=1. If tx_en=1 && fifo_empty=0 -> LOAD.
//   LOAD:   exactly one cycle. fifo_rd=1; fifo_rdata latched into the shift reg on this edge;
//           parity computed from the latched byte. -> START. fifo_rd is 1 only in LOAD, so
//           a pop is never issued while empty and never twice for one byte.
//   START:  tx=0 for DIV cycles -> DATA.
//   DATA:   8 bits, LSB first, each held DIV cycles. After bit 7 -> PARITY if PARITY!=0,
//           else -> STOP.
//   PARITY: tx = ^byte (even) or ~^byte (odd), held DIV cycles -> STOP.
//   STOP:   tx=1 for STOP_BITS*DIV cycles. tx_done=1 on the final cycle -> IDLE.
//   Baud counter: width $clog2(DIV); cleared on entry to START and at every bit boundary;
//     a bit ends when counter==DIV-1. Bit timing is exact: no drift accumulates across bits.
//   Back-to-back frames: IDLE is always occupied for exactly 1 cycle between frames.
//     Byte period = 2 + (1 + 8 + P + STOP_BITS)*DIV cycles, where P = (PARITY!=0).
//   tx_en=0 mid-frame: no effect; the current frame completes, then the block holds IDLE.
//   fifo_empty going high mid-frame: no effect on the current frame.
//   Inputs other than reset are not synchronized; the FIFO shares clk.
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10; PARITY=0, STOP_BITS=1 unless noted)
//   1 Single byte: write 8'hA5, tx_en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 with
//     each bit 10 cycles long; tx_done pulses at LOAD+100; fifo_empty=1 afterwards.
//   2 Burst: write 16 bytes 8'h00..8'h0F (FIFO full) -> 16 frames decoded in order; start
//     edges exactly 102 cycles apart; exactly 16 fifo_rd pulses.
//   3 Parity: PARITY=1, send 8'h07 -> parity bit=1; PARITY=2, send 8'h07 -> parity bit=0;
//     frame length 110 cycles.
//   4 Gating: tx_en=0 with 3 bytes queued -> tx stays 1, no fifo_rd. Drop tx_en to 0 during
//     bit 3 of a frame -> that frame completes, the next frame does not start.
//   5 Reset mid-frame: assert reset during DATA bit 4 -> tx=1 and tx_busy=0 in the same
//     cycle; after release with 1 byte left -> next frame carries the next FIFO byte.
//   6 Empty: fifo_empty=1, tx_en=1 for 500 cycles -> fifo_rd never asserted, tx=1 throughout.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
`timescale 1ns/1ps
// UART transmitter that drains a show-ahead byte FIFO and sends 8N1/8E1/8O1 frames on tx.
// All outputs are registered and computed from the next-state values.
module uart_tx_fifo_drain #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          stop_q, stop_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_q, rd_d;
   logic          bit_end_s;
   logic          stop_last_s;
   logic          stop_last_d_s;

   function automatic logic calc_parity(input logic [7:0] b);
      if (PARITY == 1) begin
         return ^b;
      end else begin
         return ~^b;
      end
   endfunction

   // Next-state, counters and the registered output values for the coming cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      par_d         = par_q;
      stop_d        = stop_q;
      bit_end_s     = (cnt_q == CNT_LAST);
      stop_last_s   = (STOP_BITS == 1) ? 1'b1 : stop_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = 3'd0;
            if (tx_en && !fifo_empty) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            shift_d = fifo_rdata;
            par_d   = calc_parity(fifo_rdata);
            cnt_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end_s) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  stop_d = 1'b0;
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               cnt_d   = '0;
               stop_d  = 1'b0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_STOP: begin
            if (bit_end_s) begin
               cnt_d = '0;
               if (stop_last_s) begin
                  state_d = S_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = 3'd0;
         end
      endcase

      stop_last_d_s = (STOP_BITS == 1) ? 1'b1 : stop_d;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[bit_d];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      rd_d   = (state_d == S_LOAD);
      done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && stop_last_d_s;
   end

   // State and output registers; reset drops any frame in flight and forces the line high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         par_q   <= 1'b0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
      end
   end

   assign fifo_rd = rd_q;
   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule
